irr_param: RTL and testbench



---
 rtl/pic_pkg.sv | 44 ++++
 rtl/irr_param_input_cond.sv | 41 ++++
 rtl/irr_param.sv | 74 +++++++
 tb/tb_irr_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC request and in-service blocks: trigger
// constants, index sizing and the rotating priority resolver.
package pic_pkg;

  localparam int   MAX_IR     = 32;
  localparam logic TRIG_EDGE  = 1'b0;
  localparam logic TRIG_LEVEL = 1'b1;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } prio_res_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Rotate so that channel 'base' sits at bit 0, take the lowest set bit,
  // then map the position back to an absolute channel number.
  function automatic prio_res_t prio_resolve(input logic [MAX_IR-1:0] v,
                                             input int n, input int base);
    logic [MAX_IR-1:0] rot;
    logic [4:0]        j;
    prio_res_t         res;
    int                b;
    b   = (base >= n || base < 0) ? 0 : base;
    rot = '0;
    for (int k = 0; k < MAX_IR; k++) begin
      if (k < n) begin
        j      = 5'((k + b >= n) ? (k + b - n) : (k + b));
        rot[k] = v[j];
      end
    end
    res = '0;
    for (int k = MAX_IR - 1; k >= 0; k--) begin
      if (rot[k]) begin
        res.valid = 1'b1;
        res.idx   = 5'((k + b >= n) ? (k + b - n) : (k + b));
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/irr_param_input_cond.sv
// Per-channel input conditioning: synchroniser chain, previous-sample flop,
// rising-edge and trigger-mode-change detection.
module ir_input_cond
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ir,
  input  logic level_mode,
  output logic s,
  output logic rise,
  output logic mode_changed
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p_q;
  logic                   mode_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; the reset branch is in the sensitivity list, making it
  // asynchronous.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      p_q    <= 1'b0;
      mode_q <= TRIG_EDGE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ir};
      // On a mode change p also follows s, so no edge appears afterwards.
      p_q    <= sync_q[SYNC_STAGES-1];
      mode_q <= level_mode;
    end
  end

  assign s            = sync_q[SYNC_STAGES-1];
  assign rise         = s & ~p_q;
  assign mode_changed = level_mode ^ mode_q;

endmodule

// File: rtl/irr_param.sv
// Parametrised interrupt request register: synchronised edge/level capture,
// acknowledge clear and rotating-priority selection of the next request.
module irr_param
  import pic_pkg::*;
#(
  parameter  int NUM_IR      = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int IDXW        = idx_width(NUM_IR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] ir,
  input  logic [NUM_IR-1:0] level_mode,
  input  logic [NUM_IR-1:0] imr,
  input  logic              clr_valid,
  input  logic [IDXW-1:0]   clr_idx,
  input  logic [IDXW-1:0]   prio_base,
  output logic [NUM_IR-1:0] irr,
  output logic              int_req,
  output logic              hp_valid,
  output logic [IDXW-1:0]   hp_idx,
  output logic [NUM_IR-1:0] hp_onehot
);

  logic [NUM_IR-1:0] s;
  logic [NUM_IR-1:0] rise;
  logic [NUM_IR-1:0] mode_changed;
  logic [NUM_IR-1:0] clr_hit;
  prio_res_t         res;

  for (genvar i = 0; i < NUM_IR; i++) begin : g_ch
    ir_input_cond #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_cond (
      .clk          (clk),
      .reset        (reset),
      .ir           (ir[i]),
      .level_mode   (level_mode[i]),
      .s            (s[i]),
      .rise         (rise[i]),
      .mode_changed (mode_changed[i])
    );
  end

  // NOTE: defaulting clr_hit before the conditional write keeps this purely
  // combinational; without it a latch would be inferred.
  always_comb begin
    clr_hit = '0;
    if (clr_valid && int'(clr_idx) < NUM_IR) clr_hit[clr_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irr <= '0;
    end else begin
      for (int i = 0; i < NUM_IR; i++) begin
        if (mode_changed[i])
          irr[i] <= 1'b0;
        else if (level_mode[i] == TRIG_LEVEL)
          irr[i] <= s[i] & ~clr_hit[i];
        else
          // A fresh edge beats a simultaneous acknowledge so nothing is lost.
          irr[i] <= rise[i] | (irr[i] & ~clr_hit[i]);
      end
    end
  end

  assign res       = prio_resolve(MAX_IR'(irr & ~imr), NUM_IR, int'(prio_base));
  assign int_req   = res.valid;
  assign hp_valid  = res.valid;
  assign hp_idx    = IDXW'(res.idx);
  assign hp_onehot = res.valid ? (NUM_IR'(1) << res.idx) : '0;

endmodule

// File: tb/tb_irr_param.sv
// Self-checking bench for irr_param: directed scenarios plus randomized
// traffic compared each cycle against a sample-history reference model.
module tb_irr_param;

  localparam int N = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] ir, level_mode, imr, irr, hp_onehot;
  logic         clr_valid, int_req, hp_valid;
  logic [2:0]   clr_idx, prio_base, hp_idx;

  logic [8:0]   ir9, lm9, imr9, irr9, hp_onehot9;
  logic         clr_v9, int_req9, hp_valid9;
  logic [3:0]   clr_idx9, prio9, hp_idx9;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  irr_param #(.NUM_IR(N), .SYNC_STAGES(S)) u_dut (
    .clk(clk), .reset(reset), .ir(ir), .level_mode(level_mode), .imr(imr),
    .clr_valid(clr_valid), .clr_idx(clr_idx), .prio_base(prio_base),
    .irr(irr), .int_req(int_req), .hp_valid(hp_valid), .hp_idx(hp_idx),
    .hp_onehot(hp_onehot)
  );

  irr_param #(.NUM_IR(9), .SYNC_STAGES(S)) u_dut9 (
    .clk(clk), .reset(reset), .ir(ir9), .level_mode(lm9), .imr(imr9),
    .clr_valid(clr_v9), .clr_idx(clr_idx9), .prio_base(prio9),
    .irr(irr9), .int_req(int_req9), .hp_valid(hp_valid9), .hp_idx(hp_idx9),
    .hp_onehot(hp_onehot9)
  );

  // Reference model: m_hist[k] holds ir as sampled k+1 edges ago, so the
  // synchronised value is S edges old and the previous sample S+1 edges old.
  logic [N-1:0] m_hist [0:S];
  logic [N-1:0] m_irr, m_mode, m_s, m_p;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= S; k++) m_hist[k] = '0;
      m_irr  = '0;
      m_mode = '0;
    end else begin
      m_s = m_hist[S-1];
      m_p = m_hist[S];
      for (int i = 0; i < N; i++) begin
        if (level_mode[i] != m_mode[i])           m_irr[i] = 1'b0;
        else if (level_mode[i])                   m_irr[i] = m_s[i] && !(clr_valid && clr_idx == i);
        else if (m_s[i] && !m_p[i])               m_irr[i] = 1'b1;
        else if (clr_valid && clr_idx == i)       m_irr[i] = 1'b0;
      end
      m_mode = level_mode;
      for (int k = S; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = ir;
    end
  end

  function automatic int exp_winner(input logic [N-1:0] v, input int base);
    for (int k = 0; k < N; k++)
      if (v[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    int w;
    w = exp_winner(m_irr & ~imr, int'(prio_base));
    check("m_irr",     32'(irr),      32'(m_irr));
    check("m_int_req", 32'(int_req),  32'(w >= 0));
    check("m_hp_vld",  32'(hp_valid), 32'(w >= 0));
    if (w >= 0) check("m_hp_idx", 32'(hp_idx), 32'(w));
    check("m_onehot",  32'(hp_onehot), (w >= 0) ? (32'd1 << w) : 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    reset = 1'b1;
    ir = '0; level_mode = '0; imr = '0; clr_valid = 1'b0; clr_idx = '0; prio_base = '0;
    ir9 = '0; lm9 = '0; imr9 = '0; clr_v9 = 1'b0; clr_idx9 = '0; prio9 = '0;
    #3;
    check("rst_irr",    32'(irr), 0);
    check("rst_int",    32'(int_req), 0);
    check("rst_hpv",    32'(hp_valid), 0);
    check("rst_hpidx",  32'(hp_idx), 0);
    check("rst_onehot", 32'(hp_onehot), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) cycle();

    // Edge capture on ch3, then acknowledge with the line still high
    ir[3] = 1'b1;
    repeat (3) cycle();
    check("edge_irr",    32'(irr), 32'h08);
    check("edge_hpidx",  32'(hp_idx), 3);
    check("edge_int",    32'(int_req), 1);
    clr_valid = 1'b1; clr_idx = 3'd3;
    cycle();
    clr_valid = 1'b0;
    check("edge_clr", 32'(irr), 0);
    repeat (4) cycle();
    check("edge_noreset", 32'(irr), 0);
    ir[3] = 1'b0;

    // Level channel 5: clear holds for one cycle only
    level_mode[5] = 1'b1; ir[5] = 1'b1;
    repeat (5) cycle();
    check("lvl_set", 32'(irr[5]), 1);
    clr_valid = 1'b1; clr_idx = 3'd5;
    cycle();
    clr_valid = 1'b0;
    check("lvl_clr", 32'(irr[5]), 0);
    cycle();
    check("lvl_reload", 32'(irr[5]), 1);
    ir[5] = 1'b0;
    repeat (2) cycle();
    check("lvl_hold2", 32'(irr[5]), 1);
    cycle();
    check("lvl_drop3", 32'(irr[5]), 0);
    level_mode[5] = 1'b0;
    repeat (2) cycle();

    // Masking gates only the resolver, combinationally
    ir[2] = 1'b1; ir[5] = 1'b1;
    repeat (4) cycle();
    ir = '0;
    check("mask_irr", 32'(irr), 32'h24);
    imr = 8'h04; #1;
    check("mask_hp5", 32'(hp_idx), 5);
    imr = 8'h00; #1;
    check("unmask_hp2",  32'(hp_idx), 2);
    check("unmask_irr",  32'(irr), 32'h24);
    repeat (3) cycle();

    // New edge on ch2 meets an acknowledge of ch2 on the same edge
    ir[2] = 1'b1;
    repeat (2) cycle();
    clr_valid = 1'b1; clr_idx = 3'd2;
    cycle();
    clr_valid = 1'b0; ir[2] = 1'b0;
    check("collide_keep", 32'(irr[2]), 1);
    clr_valid = 1'b1; clr_idx = 3'd2; cycle();
    clr_idx = 3'd5; cycle();
    clr_valid = 1'b0;
    check("collide_clr", 32'(irr), 0);

    // Rotating priority
    ir[0] = 1'b1; ir[7] = 1'b1;
    repeat (4) cycle();
    ir = '0;
    check("rot_irr", 32'(irr), 32'h81);
    prio_base = 3'd1; #1;
    check("rot_hp7",     32'(hp_idx), 7);
    check("rot_onehot7", 32'(hp_onehot), 32'h80);
    prio_base = 3'd0; #1;
    check("rot_hp0",     32'(hp_idx), 0);
    check("rot_onehot0", 32'(hp_onehot), 32'h01);
    clr_valid = 1'b1; clr_idx = 3'd0; cycle();
    clr_idx = 3'd7; cycle();
    clr_valid = 1'b0;

    // Mode toggles on a pending channel
    ir[1] = 1'b1;
    repeat (4) cycle();
    check("mode_pend", 32'(irr[1]), 1);
    level_mode[1] = 1'b1;
    cycle();
    check("mode_clr", 32'(irr[1]), 0);
    cycle();
    check("mode_lvl", 32'(irr[1]), 1);
    level_mode[1] = 1'b0;
    cycle();
    check("mode_back", 32'(irr[1]), 0);
    repeat (4) cycle();
    check("mode_nospur", 32'(irr[1]), 0);
    ir[1] = 1'b0;

    // Out-of-range acknowledge on a 9-channel instance
    ir9[8] = 1'b1;
    repeat (4) cycle();
    check("n9_set",   32'(irr9), 32'h100);
    check("n9_hpidx", 32'(hp_idx9), 8);
    clr_v9 = 1'b1; clr_idx9 = 4'd9;
    cycle();
    check("n9_ignore", 32'(irr9), 32'h100);
    clr_idx9 = 4'd8;
    cycle();
    clr_v9 = 1'b0;
    check("n9_clr", 32'(irr9), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      ir        = ir ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) level_mode[$urandom_range(0, N-1)] ^= 1'b1;
      imr       = 8'($urandom & $urandom);
      clr_valid = ($urandom_range(0, 2) == 0);
      clr_idx   = 3'($urandom);
      prio_base = 3'($urandom);
      cycle();
    end

    // Asynchronous reset mid-cycle with every channel pending
    ir = '0; level_mode = '0; imr = '0; clr_valid = 1'b0; prio_base = '0;
    repeat (4) cycle();
    ir = 8'hFF;
    repeat (4) cycle();
    check("pre_rst_irr", 32'(irr), 32'hFF);
    @(negedge clk); #2;
    reset = 1'b1; #1;
    check("arst_irr",    32'(irr), 0);
    check("arst_int",    32'(int_req), 0);
    check("arst_hpv",    32'(hp_valid), 0);
    check("arst_hpidx",  32'(hp_idx), 0);
    check("arst_onehot", 32'(hp_onehot), 0);
    check("arst_irr9",   32'(irr9), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) cycle();
    check("post_rst_latch", 32'(irr), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
